// File: rtl/register_writer_pkg.sv
// Opcode and load-width constants shared by the core stages, plus the
// writeback source decode and load extraction helpers used by register_writer.
package register_writer_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        WB_SRC_NONE,
        WB_SRC_IMM,
        WB_SRC_RES,
        WB_SRC_LOAD
    } wb_src_e;

    function automatic wb_src_e wb_source(input logic [6:0] opcode);
        case (opcode)
            OPC_LUI:                                       return WB_SRC_IMM;
            OPC_OP, OPC_OP_IMM, OPC_JAL, OPC_JALR, OPC_AUIPC: return WB_SRC_RES;
            OPC_LOAD:                                      return WB_SRC_LOAD;
            default:                                       return WB_SRC_NONE;
        endcase
    endfunction

    function automatic logic load_width_ok(input logic [2:0] funct3);
        return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
               (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

    // Halfword pick ignores addr_lo[0]; misaligned halfwords are not realigned here.
    function automatic logic [31:0] load_extract(input logic [31:0] mem,
                                                 input logic [2:0]  funct3,
                                                 input logic [1:0]  addr_lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = mem[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? mem[31:16] : mem[15:0];
        case (funct3)
            F3_LB:   return {{24{b[7]}}, b};
            F3_LBU:  return {24'd0, b};
            F3_LH:   return {{16{h[15]}}, h};
            F3_LHU:  return {16'd0, h};
            F3_LW:   return mem;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/register_writer_regfile.sv
// 32x32 register array: one synchronous write port, two combinational reads,
// x0 reads as zero and is never written.
module register_writer_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/register_writer.sv
// Writeback stage: selects/extracts the result, writes the register file with a
// same-cycle read bypass, records the last write and counts retired instructions.
module register_writer
    import register_writer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_noop,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_res,
    input  logic [31:0] in_mem_rd,
    input  logic [1:0]  in_addr_lo,
    input  logic [4:0]  rd1_addr,
    input  logic [4:0]  rd2_addr,
    output logic [31:0] reg_rd1_data,
    output logic [31:0] reg_rd2_data,
    output logic        out_wb_valid,
    output logic [4:0]  out_wb_rd,
    output logic [31:0] out_wb_data,
    output logic [63:0] out_instret
);

    wb_src_e     wb_src;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic [63:0] instret_q;

    always_comb begin
        wb_src  = wb_source(in_opcode);
        wr_data = in_res;
        case (wb_src)
            WB_SRC_IMM:  wr_data = in_imm;
            WB_SRC_LOAD: wr_data = load_extract(in_mem_rd, in_funct3, in_addr_lo);
            default:     wr_data = in_res;
        endcase
        // Reserved load widths still retire but never touch the register file.
        wr_en = !in_noop && !rst && (in_rd != 5'd0) && (wb_src != WB_SRC_NONE) &&
                !((wb_src == WB_SRC_LOAD) && !load_width_ok(in_funct3));
    end

    register_writer_regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wr_en),
        .waddr  (in_rd),
        .wdata  (wr_data),
        .raddr1 (rd1_addr),
        .raddr2 (rd2_addr),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2)
    );

    // During reset the array still holds old data until the edge, so reads are masked.
    always_comb begin
        reg_rd1_data = rf_rd1;
        reg_rd2_data = rf_rd2;
        if (rst) begin
            reg_rd1_data = 32'd0;
            reg_rd2_data = 32'd0;
        end else begin
            if (wr_en && (rd1_addr == in_rd)) reg_rd1_data = wr_data;
            if (wr_en && (rd2_addr == in_rd)) reg_rd2_data = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_wb_valid <= 1'b0;
            out_wb_rd    <= 5'd0;
            out_wb_data  <= 32'd0;
            instret_q    <= 64'd0;
        end else begin
            out_wb_valid <= wr_en;
            out_wb_rd    <= in_rd;
            out_wb_data  <= wr_data;
            if (!in_noop) instret_q <= instret_q + 64'd1;
        end
    end

    assign out_instret = instret_q;

endmodule

// File: tb/tb_register_writer.sv
// Directed and random stimulus for register_writer against a behavioural
// register-file/retire-count model.
module tb_register_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_noop;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic [31:0] in_imm;
    logic [31:0] in_res;
    logic [31:0] in_mem_rd;
    logic [1:0]  in_addr_lo;
    logic [4:0]  rd1_addr;
    logic [4:0]  rd2_addr;
    logic [31:0] reg_rd1_data;
    logic [31:0] reg_rd2_data;
    logic        out_wb_valid;
    logic [4:0]  out_wb_rd;
    logic [31:0] out_wb_data;
    logic [63:0] out_instret;

    register_writer dut (
        .clk          (clk),
        .rst          (rst),
        .in_noop      (in_noop),
        .in_opcode    (in_opcode),
        .in_funct3    (in_funct3),
        .in_rd        (in_rd),
        .in_imm       (in_imm),
        .in_res       (in_res),
        .in_mem_rd    (in_mem_rd),
        .in_addr_lo   (in_addr_lo),
        .rd1_addr     (rd1_addr),
        .rd2_addr     (rd2_addr),
        .reg_rd1_data (reg_rd1_data),
        .reg_rd2_data (reg_rd2_data),
        .out_wb_valid (out_wb_valid),
        .out_wb_rd    (out_wb_rd),
        .out_wb_data  (out_wb_data),
        .out_instret  (out_instret)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] ref_regs [32];
    logic [63:0] ref_instret;
    logic        ref_wb_valid;
    logic [4:0]  ref_wb_rd;
    logic [31:0] ref_wb_data;

    logic [6:0] opc_list [10] = '{7'b0110111, 7'b0110011, 7'b0010011, 7'b1101111,
                                  7'b1100111, 7'b0010111, 7'b0000011, 7'b0100011,
                                  7'b1100011, 7'b1110011};

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected write from the instruction rules, computed with plain arithmetic.
    task automatic model_write(output logic we, output logic [31:0] wd);
        logic        writer;
        logic [31:0] byte_v;
        logic [31:0] half_v;
        writer = (in_opcode == 7'b0110111) || (in_opcode == 7'b0110011) ||
                 (in_opcode == 7'b0010011) || (in_opcode == 7'b1101111) ||
                 (in_opcode == 7'b1100111) || (in_opcode == 7'b0010111) ||
                 (in_opcode == 7'b0000011);
        byte_v = (in_mem_rd >> (8 * in_addr_lo)) & 32'hFF;
        half_v = (in_addr_lo >= 2) ? (in_mem_rd >> 16) : (in_mem_rd & 32'hFFFF);
        wd = in_res;
        if (in_opcode == 7'b0110111) wd = in_imm;
        if (in_opcode == 7'b0000011) begin
            case (in_funct3)
                3'd0: wd = (byte_v >= 128) ? (byte_v | 32'hFFFFFF00) : byte_v;
                3'd4: wd = byte_v;
                3'd1: wd = (half_v >= 32768) ? (half_v | 32'hFFFF0000) : half_v;
                3'd5: wd = half_v;
                3'd2: wd = in_mem_rd;
                default: writer = 1'b0;
            endcase
        end
        we = writer && !rst && !in_noop && (in_rd != 0);
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a, input logic we, input logic [31:0] wd);
        if (rst) return 32'd0;
        if (we && a == in_rd) return wd;
        return (a == 0) ? 32'd0 : ref_regs[a];
    endfunction

    // One cycle with the currently driven inputs; entered and left just after a falling edge.
    task automatic run_cycle();
        logic        we;
        logic [31:0] wd;
        #1;
        model_write(we, wd);
        check_val("rd1_data", {32'd0, reg_rd1_data}, {32'd0, exp_read(rd1_addr, we, wd)});
        check_val("rd2_data", {32'd0, reg_rd2_data}, {32'd0, exp_read(rd2_addr, we, wd)});
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
            ref_instret  = 64'd0;
            ref_wb_valid = 1'b0;
            ref_wb_rd    = 5'd0;
            ref_wb_data  = 32'd0;
        end else begin
            if (we) ref_regs[in_rd] = wd;
            if (!in_noop) ref_instret = ref_instret + 64'd1;
            ref_wb_valid = we;
            ref_wb_rd    = in_rd;
            ref_wb_data  = wd;
        end
        #1;
        check_val("wb_valid", {63'd0, out_wb_valid}, {63'd0, ref_wb_valid});
        if (ref_wb_valid) begin
            check_val("wb_rd", {59'd0, out_wb_rd}, {59'd0, ref_wb_rd});
            check_val("wb_data", {32'd0, out_wb_data}, {32'd0, ref_wb_data});
        end
        check_val("instret", out_instret, ref_instret);
        @(negedge clk);
    endtask

    task automatic drive(input logic noop, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] res,
                         input logic [31:0] mem, input logic [1:0] alo,
                         input logic [4:0] a1, input logic [4:0] a2);
        in_noop = noop; in_opcode = op; in_funct3 = f3; in_rd = rd; in_imm = imm;
        in_res = res; in_mem_rd = mem; in_addr_lo = alo; rd1_addr = a1; rd2_addr = a2;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'hX;
        ref_instret = 64'hX;
        rst = 1'b1;
        drive(1'b1, 7'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 2'd0, 5'd0, 5'd0);
        @(negedge clk);
        run_cycle();
        run_cycle();
        check_val("reset_instret", out_instret, 64'd0);
        check_val("reset_wb_valid", {63'd0, out_wb_valid}, 64'd0);
        rst = 1'b0;

        // LUI with same-cycle bypass, then read back from the array
        drive(1'b0, 7'b0110111, 3'd0, 5'd5, 32'h12345000, 32'h0, 32'h0, 2'd0, 5'd5, 5'd0);
        #1 check_val("lui_bypass", {32'd0, reg_rd1_data}, 64'h12345000);
        run_cycle();
        drive(1'b1, 7'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 2'd0, 5'd5, 5'd0);
        #1 check_val("lui_array", {32'd0, reg_rd1_data}, 64'h12345000);
        run_cycle();

        // Load extraction
        drive(1'b0, 7'b0000011, 3'b000, 5'd10, 32'd0, 32'd0, 32'h80FF7F01, 2'd3, 5'd10, 5'd5);
        #1 check_val("lb", {32'd0, reg_rd1_data}, 64'hFFFFFF80);
        run_cycle();
        drive(1'b0, 7'b0000011, 3'b100, 5'd11, 32'd0, 32'd0, 32'h80FF7F01, 2'd3, 5'd11, 5'd10);
        #1 check_val("lbu", {32'd0, reg_rd1_data}, 64'h00000080);
        run_cycle();
        drive(1'b0, 7'b0000011, 3'b101, 5'd12, 32'd0, 32'd0, 32'h80FF7F01, 2'd2, 5'd12, 5'd11);
        #1 check_val("lhu", {32'd0, reg_rd1_data}, 64'h000080FF);
        run_cycle();
        drive(1'b0, 7'b0000011, 3'b111, 5'd12, 32'd0, 32'd0, 32'h11223344, 2'd0, 5'd12, 5'd0);
        #1 check_val("load_rsvd", {32'd0, reg_rd1_data}, 64'h000080FF);
        run_cycle();

        // Writes to x0 vanish but still retire
        drive(1'b0, 7'b0110011, 3'd0, 5'd0, 32'd0, 32'hDEADBEEF, 32'd0, 2'd0, 5'd0, 5'd0);
        #1 check_val("x0_read", {32'd0, reg_rd1_data}, 64'd0);
        run_cycle();

        // Bubble and store
        drive(1'b1, 7'b0110011, 3'd0, 5'd3, 32'd0, 32'h33, 32'd0, 2'd0, 5'd3, 5'd0);
        run_cycle();
        drive(1'b0, 7'b0100011, 3'd2, 5'd3, 32'd0, 32'h44, 32'd0, 2'd0, 5'd3, 5'd0);
        run_cycle();

        // Reset overrides a presented write
        drive(1'b0, 7'b0110011, 3'd0, 5'd7, 32'd0, 32'h55, 32'd0, 2'd0, 5'd7, 5'd0);
        run_cycle();
        rst = 1'b1;
        drive(1'b0, 7'b0110011, 3'd0, 5'd7, 32'd0, 32'd9, 32'd0, 2'd0, 5'd7, 5'd0);
        run_cycle();
        rst = 1'b0;
        check_val("rst_instret", out_instret, 64'd0);
        check_val("rst_wb_valid", {63'd0, out_wb_valid}, 64'd0);
        drive(1'b1, 7'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 2'd0, 5'd7, 5'd0);
        #1 check_val("rst_x7", {32'd0, reg_rd1_data}, 64'd0);
        run_cycle();

        // Retire counter wrap
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.instret_q;
        ref_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        check_val("instret_preload", out_instret, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b0, 7'b0110011, 3'd0, 5'd1, 32'd0, 32'd1, 32'd0, 2'd0, 5'd1, 5'd0);
        run_cycle();
        check_val("instret_wrap", out_instret, 64'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic [4:0] rd_r;
            rd_r = 5'($urandom_range(0, 31));
            rst = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 5) == 0,
                  opc_list[$urandom_range(0, 9)],
                  3'($urandom_range(0, 7)),
                  rd_r,
                  $urandom, $urandom, $urandom,
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) == 0) ? rd_r : 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)));
            run_cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
